phys_reg_freelist: RTL and testbench
====================================

Name: phys_reg_freelist

Overview:
- Allocator for the physical register file's renameable tags. Tags 0 and 1 are hardwired constants and are never allocated.
- Holds free tags in a circular queue. The rename stage pops up to ALLOC_W tags per cycle; retirement pushes up to FREE_W released tags per cycle.
- Keeps a speculative head and a committed head, so a pipeline flush returns all uncommitted allocations in one cycle.

Parameters:
- NUM_PREGS, 32, total physical tags including constants 0 and 1.
- TAG_W, 5, tag width.
- NUM_ARCH, 6, tags 2..NUM_ARCH+1 hold the initial architectural mapping and are not free at reset.
- ALLOC_W, 2, max tags allocated per cycle.
- FREE_W, 2, max tags freed per cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_count  in  clog2(ALLOC_W+1)  tags requested this cycle (0..ALLOC_W)
- alloc_ok  out  1  spec_count >= alloc_count
- alloc_tags  out  ALLOC_W*TAG_W  next tags from the speculative head; slot 0 is oldest
- commit_count  in  clog2(ALLOC_W+1)  allocations made architectural this cycle
- flush  in  1  discard all uncommitted allocations
- free_valid  in  FREE_W  per-slot push valid
- free_tags  in  FREE_W*TAG_W  released tags
- free_count  out  TAG_W+1  entries between the speculative head and the tail
- err  out  1  sticky error flag

Behaviour:
- Storage: queue of Q = NUM_PREGS-2 entries. Registers: spec_head, commit_head, tail, spec_count, commit_count_r, err.
- Reset:
  - Queue holds tags NUM_ARCH+2..NUM_PREGS-1 in ascending order at indices 0..Q-NUM_ARCH-1.
  - spec_head = commit_head = 0, tail = Q-NUM_ARCH.
  - spec_count = commit_count_r = 24 (defaults), err = 0.
  - With defaults: alloc_tags = {9,8} (slot0 = 8), alloc_ok = 1.
- Allocation:
  - alloc_tags are driven combinationally from registered state (0-cycle read).
  - When alloc_count > 0 and alloc_ok = 1: spec_head += alloc_count mod Q; spec_count -= alloc_count.
  - When alloc_ok = 0: no state change. Rename stalls; there is no partial allocation.
  - Slots beyond spec_count drive tag 0.
- Free:
  - Valid slots are pushed in ascending slot order, compacted: tail += number pushed, both counts += number pushed.
  - Slots carrying tag 0 or 1 are dropped silently.
  - Pushed tags become allocatable no earlier than the next cycle; same-cycle bypass to alloc_tags is forbidden.
- Commit:
  - commit_head += commit_count; commit_count_r -= commit_count.
  - If commit_count exceeds outstanding allocations (commit_count_r - spec_count): err = 1 and the commit is ignored.
- Flush:
  - spec_head <= commit_head and spec_count <= commit_count_r, taking into account same-cycle frees and commit.
  - Any same-cycle allocation is ignored. Commit is applied before the restore.
- Simultaneous alloc and free: net update. When spec_count = 0 and a free arrives, alloc_ok stays 0 that cycle and goes 1 the next.
- Overflow: a push that would make commit_count_r exceed Q sets err and drops the excess slots.
- Wrap-around: all pointers wrap mod Q; Q need not be a power of two.
- err clears only on rst.

Optional Feature:
- Macro: FREELIST_DUPCHK_EN.
- Defined:
  - Keeps an NUM_PREGS-bit free bitmap, reset to ones for the initially free tags.
  - Allocation clears the tag's bit. Flush sets the bits of the returned tags, which needs a per-entry walk or shadow bitmap.
  - Freeing a tag whose bit is already set, or two identical tags in one cycle, sets err and drops the duplicate.
- Undefined: no bitmap; err arises only from overflow or bad commit.

Test Plan:
- Reset then idle: alloc_tags slot0 = 8, slot1 = 9, free_count = 24, alloc_ok = 1, err = 0.
- alloc_count = 2 for 12 cycles with no frees: tags 8..31 issued in order, free_count = 0, alloc_ok = 0; alloc_count = 1 then causes no state change.
- From empty, free_valid = 2'b11 with tags {12,5}: same cycle alloc_ok = 0; next cycle alloc_tags = {12,5} (slot0 = 5), free_count = 2.
- Allocate 4 (8..11), commit 2, flush: next cycle alloc_tags slot0 = 10, free_count = 22.
- Free tag 0 and tag 1 with both slots valid: no change, free_count unchanged, err = 0.
- With FREELIST_DUPCHK_EN, free tag 20 while 20 is still free: err = 1, free_count unchanged. Without the macro, the same stimulus is pushed and err = 0.

Source files
------------

// File: rtl/phys_reg_freelist.sv
// rtl/phys_reg_freelist.sv - circular free list of physical register tags with speculative and committed heads
// Define FREELIST_DUPCHK_EN to add a free bitmap that rejects double frees.
module phys_reg_freelist #(
    parameter int NUM_PREGS = 32,
    parameter int TAG_W     = 5,
    parameter int NUM_ARCH  = 6,
    parameter int ALLOC_W   = 2,
    parameter int FREE_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(ALLOC_W+1)-1:0] alloc_count,
    output logic                         alloc_ok,
    output logic [ALLOC_W*TAG_W-1:0]     alloc_tags,
    input  logic [$clog2(ALLOC_W+1)-1:0] commit_count,
    input  logic                         flush,
    input  logic [FREE_W-1:0]            free_valid,
    input  logic [FREE_W*TAG_W-1:0]      free_tags,
    output logic [TAG_W:0]               free_count,
    output logic                         err
);
    localparam int Q         = NUM_PREGS - 2;
    localparam int IDX_W     = $clog2(Q);
    localparam int CNT_W     = TAG_W + 1;
    localparam int INIT_FREE = Q - NUM_ARCH;

    logic [TAG_W-1:0]  mem [Q];
    logic [IDX_W-1:0]  spec_head, commit_head, tail;
    logic [CNT_W-1:0]  spec_count, commit_count_r;

    logic [IDX_W-1:0]  spec_head_n, commit_head_n, tail_n;
    logic [CNT_W-1:0]  spec_count_n, commit_count_n;
    logic              err_n;
    logic              alloc_fire;
    logic [FREE_W-1:0] push_en;
    logic [IDX_W-1:0]  push_idx [FREE_W];

`ifdef FREELIST_DUPCHK_EN
    logic [NUM_PREGS-1:0] free_map, free_map_n;
`endif

    // Pointers never exceed Q-1 and increments are small, so one conditional subtract wraps.
    function automatic logic [IDX_W-1:0] wrap_add(input int a, input int b);
        int s;
        s = a + b;
        if (s >= Q) s = s - Q;
        return IDX_W'(s);
    endfunction

    always_comb begin
        alloc_tags = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (i < int'(spec_count))
                alloc_tags[i*TAG_W +: TAG_W] = mem[wrap_add(int'(spec_head), i)];
        end
    end

    assign alloc_ok   = int'(spec_count) >= int'(alloc_count);
    assign free_count = spec_count;

    always_comb begin
        int n_push;
        int outstanding;
        int commit_eff;
        int alloc_eff;
        logic [TAG_W-1:0] tag;
        logic dup;
        logic bad_commit;
`ifdef FREELIST_DUPCHK_EN
        logic [NUM_PREGS-1:0] seen;
        int d;
        seen = free_map;
        d    = 0;
`endif
        n_push  = 0;
        err_n   = err;
        push_en = '0;
        tag     = '0;
        dup     = 1'b0;
        for (int s = 0; s < FREE_W; s++) push_idx[s] = '0;

        // Compact valid releases onto the tail; constant tags are dropped, overflow is clipped.
        for (int s = 0; s < FREE_W; s++) begin
            tag = free_tags[s*TAG_W +: TAG_W];
            dup = 1'b0;
`ifdef FREELIST_DUPCHK_EN
            dup = seen[tag];
`endif
            if (free_valid[s] && tag > TAG_W'(1)) begin
                if (dup) begin
                    err_n = 1'b1;
                end else if (int'(commit_count_r) + n_push >= Q) begin
                    err_n = 1'b1;
                end else begin
                    push_en[s]  = 1'b1;
                    push_idx[s] = wrap_add(int'(tail), n_push);
                    n_push      = n_push + 1;
`ifdef FREELIST_DUPCHK_EN
                    seen[tag]   = 1'b1;
`endif
                end
            end
        end

        outstanding = int'(commit_count_r) - int'(spec_count);
        bad_commit  = int'(commit_count) > outstanding;
        commit_eff  = bad_commit ? 0 : int'(commit_count);
        if (bad_commit) err_n = 1'b1;

        alloc_fire = !flush && (alloc_count != '0) && alloc_ok;
        alloc_eff  = alloc_fire ? int'(alloc_count) : 0;

        commit_head_n  = wrap_add(int'(commit_head), commit_eff);
        commit_count_n = CNT_W'(int'(commit_count_r) - commit_eff + n_push);
        tail_n         = wrap_add(int'(tail), n_push);

        if (flush) begin
            spec_head_n  = commit_head_n;
            spec_count_n = commit_count_n;
        end else begin
            spec_head_n  = wrap_add(int'(spec_head), alloc_eff);
            spec_count_n = CNT_W'(int'(spec_count) - alloc_eff + n_push);
        end

`ifdef FREELIST_DUPCHK_EN
        free_map_n = free_map;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (i < alloc_eff)
                free_map_n[mem[wrap_add(int'(spec_head), i)]] = 1'b0;
        end
        // Walk the queue: entries from the new commit head up to the old speculative head return to the free set.
        if (flush) begin
            for (int j = 0; j < Q; j++) begin
                d = j - int'(commit_head_n);
                if (d < 0) d = d + Q;
                if (d < outstanding - commit_eff)
                    free_map_n[mem[j]] = 1'b1;
            end
        end
        for (int s = 0; s < FREE_W; s++) begin
            if (push_en[s])
                free_map_n[free_tags[s*TAG_W +: TAG_W]] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_head      <= '0;
            commit_head    <= '0;
            tail           <= IDX_W'(INIT_FREE);
            spec_count     <= CNT_W'(INIT_FREE);
            commit_count_r <= CNT_W'(INIT_FREE);
            err            <= 1'b0;
            for (int i = 0; i < Q; i++)
                mem[i] <= (i < INIT_FREE) ? TAG_W'(NUM_ARCH + 2 + i) : '0;
        end else begin
            spec_head      <= spec_head_n;
            commit_head    <= commit_head_n;
            tail           <= tail_n;
            spec_count     <= spec_count_n;
            commit_count_r <= commit_count_n;
            err            <= err_n;
            for (int s = 0; s < FREE_W; s++) begin
                if (push_en[s])
                    mem[push_idx[s]] <= free_tags[s*TAG_W +: TAG_W];
            end
        end
    end

`ifdef FREELIST_DUPCHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_PREGS; t++)
                free_map[t] <= (t >= NUM_ARCH + 2);
        end else begin
            free_map <= free_map_n;
        end
    end
`endif

endmodule

// File: tb/tb_phys_reg_freelist.sv
// tb/tb_phys_reg_freelist.sv - randomized bench for phys_reg_freelist against a queue-based free list model
module tb_phys_reg_freelist;
    localparam int NP = 32;
    localparam int TW = 5;
    localparam int Q  = 30;
    localparam int AW = 2;
    localparam int FW = 2;
`ifdef FREELIST_DUPCHK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      alloc_count = '0;
    logic            alloc_ok;
    logic [AW*TW-1:0] alloc_tags;
    logic [1:0]      commit_count = '0;
    logic            flush = 1'b0;
    logic [FW-1:0]   free_valid = '0;
    logic [FW*TW-1:0] free_tags = '0;
    logic [TW:0]     free_count;
    logic            err;

    phys_reg_freelist dut (
        .clk(clk), .rst(rst), .alloc_count(alloc_count), .alloc_ok(alloc_ok),
        .alloc_tags(alloc_tags), .commit_count(commit_count), .flush(flush),
        .free_valid(free_valid), .free_tags(free_tags), .free_count(free_count), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: fq = allocatable tags oldest first, unc = uncommitted allocations, pool = tags safe to release.
    int fq[$];
    int unc[$];
    int pool[$];
    bit is_free[NP];
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete(); unc.delete(); pool.delete();
        m_err = 1'b0;
        for (int t = 0; t < NP; t++) is_free[t] = (t >= 8);
        for (int t = 8; t < NP; t++) fq.push_back(t);
        for (int t = 2; t < 8; t++) pool.push_back(t);
    endtask

    task automatic compare_model();
        logic [AW*TW-1:0] exp_tags;
        exp_tags = '0;
        for (int i = 0; i < AW; i++)
            if (i < fq.size()) exp_tags[i*TW +: TW] = 5'(fq[i]);
        chk("alloc_ok", 32'(alloc_ok), 32'(fq.size() >= int'(alloc_count)));
        chk("alloc_tags", 32'(alloc_tags), 32'(exp_tags));
        chk("free_count", 32'(free_count), 32'(fq.size()));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic model_step();
        int ac, cc, occ, outst, t;
        bit ok;
        int pushed[$];
        bit seen[NP];
        ac = int'(alloc_count);
        cc = int'(commit_count);
        ok = fq.size() >= ac;
        occ = fq.size() + unc.size();
        outst = unc.size();
        seen = is_free;
        for (int s = 0; s < FW; s++) begin
            t = int'(free_tags[s*TW +: TW]);
            if (free_valid[s] && t > 1) begin
                if (DUP && seen[t]) m_err = 1'b1;
                else if (occ + pushed.size() >= Q) m_err = 1'b1;
                else begin
                    pushed.push_back(t);
                    seen[t] = 1'b1;
                end
            end
        end
        if (cc > outst) m_err = 1'b1;
        else repeat (cc) pool.push_back(unc.pop_front());
        if (flush) begin
            foreach (unc[k]) is_free[unc[k]] = 1'b1;
            fq = {unc, fq};
            unc.delete();
        end else if (ac > 0 && ok) begin
            repeat (ac) begin
                t = fq.pop_front();
                is_free[t] = 1'b0;
                unc.push_back(t);
            end
        end
        foreach (pushed[k]) begin
            fq.push_back(pushed[k]);
            is_free[pushed[k]] = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; alloc_count = '0; commit_count = '0; flush = 1'b0;
        free_valid = '0; free_tags = '0;
        @(posedge clk);
        model_reset();
    endtask

    task automatic drive(input int ac, input int cc, input bit fl, input logic [1:0] fv,
                         input int t0, input int t1);
        @(negedge clk);
        rst = 1'b0;
        alloc_count = 2'(ac);
        commit_count = 2'(cc);
        flush = fl;
        free_valid = fv;
        free_tags = {5'(t1), 5'(t0)};
        #1;
        compare_model();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
    endtask

    task automatic rand_cycle();
        int ac, cc, lim, idx;
        bit fl;
        logic [1:0] fv;
        int t[2];
        ac = $urandom_range(0, 2);
        lim = (unc.size() < 2) ? unc.size() : 2;
        cc = ($urandom_range(0, 63) == 0) ? 3 : $urandom_range(0, lim);
        fl = ($urandom_range(0, 15) == 0);
        for (int s = 0; s < 2; s++) begin
            fv[s] = 1'($urandom_range(0, 1));
            t[s] = 0;
            if (fv[s]) begin
                if ($urandom_range(0, 31) == 0 || pool.size() == 0) begin
                    t[s] = $urandom_range(0, 31);
                end else begin
                    idx = $urandom_range(0, pool.size() - 1);
                    t[s] = pool[idx];
                    pool.delete(idx);
                end
            end
        end
        drive(ac, cc, fl, fv, t[0], t[1]);
        advance();
    endtask

    initial begin
        // Reset then idle
        do_reset();
        drive(0, 0, 0, 2'b00, 0, 0);
        chk("reset_slot0", 32'(alloc_tags[TW-1:0]), 32'd8);
        chk("reset_slot1", 32'(alloc_tags[2*TW-1:TW]), 32'd9);
        chk("reset_free_count", 32'(free_count), 32'd24);
        chk("reset_alloc_ok", 32'(alloc_ok), 32'd1);
        chk("reset_err", 32'(err), 32'd0);
        advance();

        // Drain: 12 double allocations issue 8..31 in order
        for (int k = 0; k < 12; k++) begin
            drive(2, 0, 0, 2'b00, 0, 0);
            chk("drain_slot0", 32'(alloc_tags[TW-1:0]), 32'(8 + 2*k));
            chk("drain_slot1", 32'(alloc_tags[2*TW-1:TW]), 32'(9 + 2*k));
            advance();
        end
        drive(1, 0, 0, 2'b00, 0, 0);
        chk("empty_alloc_ok", 32'(alloc_ok), 32'd0);
        chk("empty_free_count", 32'(free_count), 32'd0);
        advance();
        drive(1, 0, 0, 2'b00, 0, 0);
        chk("stall_free_count", 32'(free_count), 32'd0);
        chk("stall_slot0", 32'(alloc_tags[TW-1:0]), 32'd0);
        advance();

        // Refill from empty: no same-cycle bypass
        drive(1, 0, 0, 2'b11, 5, 12);
        chk("refill_same_ok", 32'(alloc_ok), 32'd0);
        advance();
        drive(0, 0, 0, 2'b00, 0, 0);
        chk("refill_slot0", 32'(alloc_tags[TW-1:0]), 32'd5);
        chk("refill_slot1", 32'(alloc_tags[2*TW-1:TW]), 32'd12);
        chk("refill_free_count", 32'(free_count), 32'd2);
        advance();

        // Allocate 4, commit 2, flush
        do_reset();
        drive(2, 0, 0, 2'b00, 0, 0); advance();
        drive(2, 0, 0, 2'b00, 0, 0); advance();
        drive(0, 2, 0, 2'b00, 0, 0); advance();
        drive(0, 0, 1, 2'b00, 0, 0); advance();
        drive(0, 0, 0, 2'b00, 0, 0);
        chk("flush_slot0", 32'(alloc_tags[TW-1:0]), 32'd10);
        chk("flush_free_count", 32'(free_count), 32'd22);
        advance();

        // Constant tags are dropped
        drive(0, 0, 0, 2'b11, 0, 1); advance();
        drive(0, 0, 0, 2'b00, 0, 0);
        chk("const_free_count", 32'(free_count), 32'd22);
        chk("const_err", 32'(err), 32'd0);
        advance();

        // Release of a tag that is already free
        do_reset();
        drive(0, 0, 0, 2'b01, 20, 0); advance();
        drive(0, 0, 0, 2'b00, 0, 0);
        chk("dupfree_err", 32'(err), DUP ? 32'd1 : 32'd0);
        chk("dupfree_free_count", 32'(free_count), DUP ? 32'd24 : 32'd25);
        advance();

        // Randomized phases
        for (int ph = 0; ph < 4; ph++) begin
            do_reset();
            for (int c = 0; c < 500; c++) rand_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
